// File: rtl/fm_tx_controller.sv
// FM transmit sequencer: sample clock, source select, soft gain ramp
// and sticky underrun flag in front of the modulator audio port.
module fm_tx_controller #(
  parameter int A         = 8,
  parameter int DIV       = 1024,
  parameter int G         = 4,
  parameter int TONE_HALF = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [1:0]   src_sel,
  input  logic [A-1:0] ext_audio,
  input  logic         ext_valid,
  output logic         ext_ready,
  output logic [A-1:0] audio,
  output logic         tx_en,
  output logic         sample_tick,
  output logic         busy,
  output logic         underrun
);

  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TONE_HALF + 1);
  localparam int PW = A + G + 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [TW-1:0] TONE_MAX = TW'(TONE_HALF - 1);
  localparam logic [G:0]    FULL     = {1'b1, {G{1'b0}}};
  localparam logic [A-1:0]  TONE_POS = A'(1 << (A - 2));
  localparam logic [A-1:0]  TONE_NEG = A'(-(1 << (A - 2)));

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [G:0]    gain, gain_n;
  logic [A-1:0]  hold;
  logic          hold_valid;
  logic [A-1:0]  last_raw;
  logic [TW-1:0] tone_cnt;
  logic          tone_neg;
  logic [A-1:0]  audio_q;
  logic          underrun_q;

  logic          ext_src;
  logic          take;
  logic [A-1:0]  raw;
  logic          starve;

  logic signed [PW-1:0] raw_x;
  logic signed [PW-1:0] gain_x;
  logic signed [PW-1:0] prod;
  logic [A-1:0]         audio_n;

  assign sample_tick = (cnt == CNT_MAX);
  assign ext_src     = (src_sel == 2'd0);
  assign ext_ready   = ext_src ? ~hold_valid : 1'b1;
  assign take        = ext_valid & ext_ready;

  assign tx_en    = (state != IDLE);
  assign busy     = tx_en;
  assign audio    = audio_q;
  assign underrun = underrun_q;

  // Raw sample selection; an empty hold falls through to the live bus.
  always_comb begin
    raw    = '0;
    starve = 1'b0;
    unique case (1'b1)
      ext_src: begin
        if (hold_valid) begin
          raw = hold;
        end else if (ext_valid) begin
          raw = ext_audio;
        end else begin
          raw    = last_raw;
          starve = 1'b1;
        end
      end
      (src_sel == 2'd1): begin
        raw = tone_neg ? TONE_NEG : TONE_POS;
      end
      src_sel[1]: begin
        raw = '0;
      end
    endcase
  end

  // Direction follows enable; gain only steps on a tick.
  always_comb begin
    state_n = state;
    gain_n  = gain;
    if (state == IDLE) begin
      gain_n = '0;
      if (enable) begin
        state_n = RAMP_UP;
      end
    end else begin
      if (sample_tick) begin
        if (enable) begin
          gain_n = (gain == FULL) ? FULL : gain + (G+1)'(1);
        end else begin
          gain_n = (gain == '0) ? '0 : gain - (G+1)'(1);
        end
      end
      if (enable) begin
        state_n = (gain_n == FULL) ? ON : RAMP_UP;
      end else if (sample_tick && gain_n == '0) begin
        state_n = IDLE;
      end else begin
        state_n = RAMP_DOWN;
      end
    end
  end

  assign raw_x   = {{(G+1){raw[A-1]}}, raw};
  assign gain_x  = {{A{1'b0}}, gain_n};
  assign prod    = raw_x * gain_x;
  assign audio_n = A'(prod >>> G);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      state      <= IDLE;
      gain       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      last_raw   <= '0;
      tone_cnt   <= '0;
      tone_neg   <= 1'b0;
      audio_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      cnt   <= sample_tick ? '0 : cnt + CW'(1);
      state <= state_n;
      gain  <= gain_n;

      if (!ext_src) begin
        hold_valid <= 1'b0;
      end else if (sample_tick) begin
        hold_valid <= 1'b0;
      end else if (take) begin
        hold       <= ext_audio;
        hold_valid <= 1'b1;
      end

      if (sample_tick) begin
        last_raw <= raw;
        audio_q  <= (state == IDLE) ? '0 : audio_n;
        if (tone_cnt == TONE_MAX) begin
          tone_cnt <= '0;
          tone_neg <= ~tone_neg;
        end else begin
          tone_cnt <= tone_cnt + TW'(1);
        end
      end

      if (state == IDLE && enable) begin
        underrun_q <= 1'b0;
      end else if (sample_tick && ext_src && starve && state != IDLE) begin
        underrun_q <= 1'b1;
      end
    end
  end

endmodule
